// File: rtl/div_pkg.sv
// Shared types and constants for the signed non-restoring divider.
package div_pkg;

   localparam int DIV_W = 32;

   localparam logic [DIV_W-1:0] INT_MIN  = 32'h8000_0000;
   localparam logic [DIV_W-1:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Two's-complement magnitude; INT_MIN maps to 2^(W-1), still exact as unsigned.
   function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] x);
      return x[DIV_W-1] ? (~x + DIV_W'(1)) : x;
   endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 non-restoring iteration on a W+1-bit signed partial remainder.
module div_step
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic [W:0]   rem,
   input  logic [W-1:0] divisor,
   input  logic         next_bit,
   output logic [W:0]   new_rem,
   output logic         q_bit
);

   logic [W:0] shifted;

   // The remainder stays in [-D, D), so the shifted value still fits in W+1 bits.
   always_comb begin
      shifted = {rem[W-1:0], next_bit};
      if (rem[W]) begin
         new_rem = shifted + {1'b0, divisor};
      end else begin
         new_rem = shifted - {1'b0, divisor};
      end
      q_bit = ~new_rem[W];
   end

endmodule

// File: rtl/signed_div_32.sv
// Sequential signed divider: W non-restoring steps, one sign/remainder fix-up cycle,
// with single-cycle shortcuts for divide-by-zero and INT_MIN / -1.
module signed_div_32
   import div_pkg::*;
#(
   parameter int W = DIV_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] q,
   output logic [W-1:0] r,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output state_t       dbg_state
);

   localparam int CNT_W = $clog2(W);

   state_t state, state_nx;

   logic [W:0]       rem;
   logic [W-1:0]     quo;
   logic [W-1:0]     b_mag;
   logic             sign_a, sign_b;
   logic [CNT_W-1:0] cnt;

   logic [W:0]   step_rem;
   logic         step_qbit;
   logic [W-1:0] r_fix, q_fin, r_fin;
   logic         accept, zero_div, overflow;

   div_step #(.W(W)) u_step (
      .rem      (rem),
      .divisor  (b_mag),
      .next_bit (quo[W-1]),
      .new_rem  (step_rem),
      .q_bit    (step_qbit)
   );

   always_comb begin
      accept   = start && (state == IDLE || state == DONE);
      zero_div = (B == '0);
      overflow = (A == INT_MIN) && (B == ALL_ONES);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nx = (zero_div || overflow) ? DONE : CALC;
            end else begin
               state_nx = IDLE;
            end
         end
         CALC:    if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == CALC) || (state == FIX);
      done      = (state == DONE);
      dbg_state = state;
   end

   // Fix-up: restore a negative remainder, then apply the result signs.
   always_comb begin
      r_fix = rem[W] ? (rem[W-1:0] + b_mag) : rem[W-1:0];
      q_fin = (sign_a ^ sign_b) ? (~quo + W'(1)) : quo;
      r_fin = sign_a ? (~r_fix + W'(1)) : r_fix;
   end

   // quo starts as |A| and is shifted left each step, trading dividend bits for quotient bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem         <= '0;
         quo         <= '0;
         b_mag       <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         cnt         <= '0;
         q           <= '0;
         r           <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         if (zero_div) begin
            q           <= ALL_ONES;
            r           <= A;
            div_by_zero <= 1'b1;
         end else if (overflow) begin
            q           <= INT_MIN;
            r           <= '0;
            div_by_zero <= 1'b0;
         end else begin
            rem         <= '0;
            quo         <= magnitude(A);
            b_mag       <= magnitude(B);
            sign_a      <= A[W-1];
            sign_b      <= B[W-1];
            cnt         <= CNT_W'(W - 1);
            div_by_zero <= 1'b0;
         end
      end else begin
         case (state)
            CALC: begin
               rem <= step_rem;
               quo <= {quo[W-2:0], step_qbit};
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               q <= q_fin;
               r <= r_fin;
            end
            default: ;
         endcase
      end
   end

endmodule
